// File: rtl/systolic_mm_engine.sv
// systolic_mm_engine: output-stationary systolic matmul with
// skewed operand feed, flush sequencing and row-major drain.
module systolic_mm_engine #(
  parameter int ROWS = 4,
  parameter int COLS = 4,
  parameter int N    = 16,
  parameter int D    = 8,
  parameter int KMAX = 256
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic [$clog2(KMAX+1)-1:0] k_len,
  output logic                      busy,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [ROWS*N-1:0]         a_col,
  input  logic [COLS*N-1:0]         b_row,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [N-1:0]              out_data,
  output logic [(ROWS>1 ? $clog2(ROWS) : 1)-1:0] out_row,
  output logic [(COLS>1 ? $clog2(COLS) : 1)-1:0] out_col,
  output logic                      out_last,
  output logic                      done
);

  localparam int KW  = $clog2(KMAX+1);
  localparam int RW  = ROWS > 1 ? $clog2(ROWS) : 1;
  localparam int CW  = COLS > 1 ? $clog2(COLS) : 1;
  localparam int W2  = 2 * N;
  localparam int AW  = W2 + KW;
  localparam int RC2 = ROWS + COLS - 2;
  localparam int FW  = $clog2(ROWS + COLS);

  localparam logic signed [AW-1:0] SMAX =
    {{(AW-N+1){1'b0}}, {(N-1){1'b1}}};
  localparam logic signed [AW-1:0] SMIN =
    {{(AW-N+1){1'b1}}, {(N-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE, LOAD, FLUSH, DRAIN
  } state_t;

  state_t        state;
  logic [KW-1:0] k_q;
  logic [KW-1:0] k_cnt;
  logic [FW-1:0] f_cnt;
  logic          clr;
  logic          step;

  logic signed [N-1:0]  a_src  [ROWS];
  logic signed [N-1:0]  b_src  [COLS];
  logic signed [N-1:0]  a_edge [ROWS];
  logic signed [N-1:0]  b_edge [COLS];
  logic signed [N-1:0]  sk_a   [ROWS][ROWS];
  logic signed [N-1:0]  sk_b   [COLS][COLS];
  logic signed [N-1:0]  a_q    [ROWS][COLS];
  logic signed [N-1:0]  b_q    [ROWS][COLS];
  logic signed [N-1:0]  a_in   [ROWS][COLS];
  logic signed [N-1:0]  b_in   [ROWS][COLS];
  logic signed [W2-1:0] prod   [ROWS][COLS];
  logic signed [AW-1:0] acc    [ROWS][COLS];
  logic signed [AW-1:0] sel;
  logic signed [AW-1:0] shf;

  assign busy      = state != IDLE;
  assign in_ready  = state == LOAD;
  assign out_valid = state == DRAIN;
  assign out_last  = (state == DRAIN)
                  && (out_row == RW'(ROWS-1))
                  && (out_col == CW'(COLS-1));

  assign clr  = (state == IDLE) && start;
  assign step = ((state == LOAD) && in_valid)
             || (state == FLUSH);

  // Job sequencing: load K beats, flush the skew, drain results.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      k_q     <= '0;
      k_cnt   <= '0;
      f_cnt   <= '0;
      out_row <= '0;
      out_col <= '0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: if (start) begin
          k_q     <= (k_len > KW'(KMAX)) ? KW'(KMAX)
                                         : k_len;
          k_cnt   <= '0;
          f_cnt   <= '0;
          out_row <= '0;
          out_col <= '0;
          state   <= (k_len == '0) ? DRAIN : LOAD;
        end
        LOAD: if (in_valid) begin
          k_cnt <= k_cnt + KW'(1);
          if (k_cnt + KW'(1) == k_q)
            state <= (RC2 == 0) ? DRAIN : FLUSH;
        end
        FLUSH: begin
          f_cnt <= f_cnt + FW'(1);
          if (f_cnt == FW'(RC2-1))
            state <= DRAIN;
        end
        DRAIN: if (out_ready) begin
          if (out_last) begin
            state <= IDLE;
            done  <= 1'b1;
          end else if (out_col == CW'(COLS-1)) begin
            out_col <= '0;
            out_row <= out_row + RW'(1);
          end else begin
            out_col <= out_col + CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Edge sources: live operands in LOAD, zeros while flushing.
  always_comb begin
    for (int i = 0; i < ROWS; i++)
      a_src[i] = (state == LOAD) ? a_col[i*N +: N] : '0;
    for (int j = 0; j < COLS; j++)
      b_src[j] = (state == LOAD) ? b_row[j*N +: N] : '0;
  end

  // Skew taps: lane i leaves after i registers.
  always_comb begin
    a_edge[0] = a_src[0];
    for (int i = 1; i < ROWS; i++)
      a_edge[i] = sk_a[i][i];
    b_edge[0] = b_src[0];
    for (int j = 1; j < COLS; j++)
      b_edge[j] = sk_b[j][j];
  end

  // Mesh wiring: PE inputs come from edge or neighbour regs.
  always_comb begin
    for (int i = 0; i < ROWS; i++) begin
      for (int j = 0; j < COLS; j++) begin
        a_in[i][j] = (j == 0) ? a_edge[i] : a_q[i][j];
        b_in[i][j] = (i == 0) ? b_edge[j] : b_q[i][j];
        prod[i][j] = W2'(a_in[i][j]) * W2'(b_in[i][j]);
      end
    end
  end

  // Array step: shift skew/mesh and accumulate, or clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < ROWS; i++)
        for (int j = 0; j < COLS; j++) begin
          acc[i][j] <= '0;
          a_q[i][j] <= '0;
          b_q[i][j] <= '0;
        end
      for (int i = 0; i < ROWS; i++)
        for (int t = 0; t < ROWS; t++)
          sk_a[i][t] <= '0;
      for (int j = 0; j < COLS; j++)
        for (int t = 0; t < COLS; t++)
          sk_b[j][t] <= '0;
    end else if (clr || step) begin
      for (int i = 0; i < ROWS; i++)
        for (int j = 0; j < COLS; j++)
          acc[i][j] <= clr ? '0
                     : acc[i][j] + AW'(prod[i][j]);
      for (int i = 0; i < ROWS; i++)
        for (int j = 1; j < COLS; j++)
          a_q[i][j] <= clr ? '0 : a_in[i][j-1];
      for (int i = 1; i < ROWS; i++)
        for (int j = 0; j < COLS; j++)
          b_q[i][j] <= clr ? '0 : b_in[i-1][j];
      for (int i = 1; i < ROWS; i++) begin
        sk_a[i][1] <= clr ? '0 : a_src[i];
        for (int t = 2; t <= i; t++)
          sk_a[i][t] <= clr ? '0 : sk_a[i][t-1];
      end
      for (int j = 1; j < COLS; j++) begin
        sk_b[j][1] <= clr ? '0 : b_src[j];
        for (int t = 2; t <= j; t++)
          sk_b[j][t] <= clr ? '0 : sk_b[j][t-1];
      end
    end
  end

  // Result select: rescale by D and saturate to N bits.
  always_comb begin
    sel      = acc[out_row][out_col];
    shf      = sel >>> D;
    out_data = shf[N-1:0];
    if (shf > SMAX)
      out_data = SMAX[N-1:0];
    else if (shf < SMIN)
      out_data = SMIN[N-1:0];
  end

endmodule

// File: tb/tb_systolic_mm_engine.sv
// tb_systolic_mm_engine: randomized jobs against a plain
// matrix-product reference with saturation.
module tb_systolic_mm_engine;

  localparam int ROWS = 2;
  localparam int COLS = 2;
  localparam int N    = 16;
  localparam int D    = 8;
  localparam int KMAX = 8;
  localparam int KW   = $clog2(KMAX+1);
  localparam int RW   = ROWS > 1 ? $clog2(ROWS) : 1;
  localparam int CW   = COLS > 1 ? $clog2(COLS) : 1;
  localparam longint MAXV = (longint'(1) <<< (N-1)) - 1;
  localparam longint MINV = -(longint'(1) <<< (N-1));

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              start = 1'b0;
  logic [KW-1:0]     k_len = '0;
  logic              busy;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [ROWS*N-1:0] a_col = '0;
  logic [COLS*N-1:0] b_row = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [N-1:0]      out_data;
  logic [RW-1:0]     out_row;
  logic [CW-1:0]     out_col;
  logic              out_last;
  logic              done;

  systolic_mm_engine #(
    .ROWS(ROWS), .COLS(COLS), .N(N),
    .D(D), .KMAX(KMAX)
  ) dut (
    .clk(clk), .reset(reset), .start(start),
    .k_len(k_len), .busy(busy),
    .in_valid(in_valid), .in_ready(in_ready),
    .a_col(a_col), .b_row(b_row),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_row(out_row),
    .out_col(out_col), .out_last(out_last),
    .done(done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int A [ROWS][KMAX];
  int B [KMAX][COLS];

  task automatic check(input string tag,
                       input logic signed [63:0] got,
                       input logic signed [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d",
               tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  function automatic longint model(int i, int j, int k);
    longint s;
    s = 0;
    for (int t = 0; t < k; t++)
      s += longint'(A[i][t]) * longint'(B[t][j]);
    s = s >>> D;
    if (s > MAXV) s = MAXV;
    if (s < MINV) s = MINV;
    return s;
  endfunction

  task automatic fill(input bit full);
    logic signed [N-1:0] v;
    for (int i = 0; i < ROWS; i++)
      for (int k = 0; k < KMAX; k++) begin
        v = N'($urandom);
        A[i][k] = full ? int'(v)
                : int'($urandom_range(0, 600)) - 300;
      end
    for (int k = 0; k < KMAX; k++)
      for (int j = 0; j < COLS; j++) begin
        v = N'($urandom);
        B[k][j] = full ? int'(v)
                : int'($urandom_range(0, 600)) - 300;
      end
  endtask

  task automatic fill_const(input int av, input int bv);
    for (int i = 0; i < ROWS; i++)
      for (int k = 0; k < KMAX; k++) A[i][k] = av;
    for (int k = 0; k < KMAX; k++)
      for (int j = 0; j < COLS; j++) B[k][j] = bv;
  endtask

  task automatic drive_beat(input int k);
    for (int i = 0; i < ROWS; i++)
      a_col[i*N +: N] = N'(A[i][k]);
    for (int j = 0; j < COLS; j++)
      b_row[j*N +: N] = N'(B[k][j]);
  endtask

  task automatic junk_inputs;
    a_col = (ROWS*N)'({$urandom, $urandom});
    b_row = (COLS*N)'({$urandom, $urandom});
  endtask

  task automatic run_job(input int kreq, input int gap,
                         input int smode, input bit poke);
    int keff;
    int t0;
    int lat;
    int idx;
    int p;
    int w;
    logic [N-1:0]  hd;
    logic [RW-1:0] hr;
    logic [CW-1:0] hc;
    logic          hl;
    keff = (kreq > KMAX) ? KMAX : kreq;
    start = 1'b1;
    k_len = KW'(kreq);
    tick;
    start = 1'b0;
    t0 = cyc;
    check("busy_after_start", busy, 1);
    check("done_cleared", done, 0);
    if (keff == 0) check("k0_no_ready", in_ready, 0);
    for (int k = 0; k < keff; k++) begin
      if (gap > 0 && k > 0) begin
        in_valid = 1'b0;
        junk_inputs();
        repeat (gap) tick;
      end
      drive_beat(k);
      in_valid = 1'b1;
      w = 0;
      while (!in_ready && w < 100) begin
        tick;
        w++;
      end
      check("in_ready_beat", in_ready, 1);
      tick;
    end
    in_valid = 1'b0;
    junk_inputs();
    if (keff > 0) check("ready_after_beats", in_ready, 0);
    w = 0;
    while (!out_valid && w < 200) begin
      tick;
      w++;
    end
    lat = (keff == 0) ? 0
        : keff + ROWS + COLS - 2 + gap * (keff - 1);
    check("first_valid_lat", cyc - t0, lat);
    check("in_ready_drain", in_ready, 0);
    idx = 0;
    p = 0;
    w = 0;
    while (idx < ROWS * COLS && w < 500) begin
      if (smode == 0) out_ready = 1'b1;
      else if (smode == 1)
        out_ready = (p % 4 == 0) || (p % 4 == 3);
      else out_ready = 1'($urandom_range(0, 1));
      start = poke && (p == 0);
      if (poke && p == 0) k_len = KW'(5);
      if (!out_valid) begin
        check("valid_held", out_valid, 1);
        break;
      end else if (out_ready) begin
        check("data", $signed(out_data),
              model(idx / COLS, idx % COLS, keff));
        check("row", out_row, idx / COLS);
        check("col", out_col, idx % COLS);
        check("last", out_last, idx == ROWS*COLS-1);
        idx++;
        tick;
      end else begin
        hd = out_data;
        hr = out_row;
        hc = out_col;
        hl = out_last;
        tick;
        check("hold_data", out_data, hd);
        check("hold_row", out_row, hr);
        check("hold_col", out_col, hc);
        check("hold_last", out_last, hl);
      end
      p++;
      w++;
    end
    start = 1'b0;
    out_ready = 1'b0;
    if (idx < ROWS * COLS)
      check("drain_count", idx, ROWS * COLS);
    check("done_pulse", done, 1);
    check("idle_valid", out_valid, 0);
    check("idle_busy", busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    #1 reset = 1'b0;
    #2;
    check("rst_busy", busy, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_last", out_last, 0);
    check("rst_done", done, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_row", out_row, 0);
    check("rst_out_col", out_col, 0);
    @(posedge clk);
    #1 reset = 1'b1;
    tick;

    fill_const(0, 0);
    A[0][0] = 256;
    A[1][1] = 256;
    B[0][0] = 256;
    B[0][1] = 512;
    B[1][0] = 768;
    B[1][1] = 1024;
    run_job(2, 0, 0, 0);
    run_job(2, 3, 0, 0);
    run_job(2, 0, 1, 0);

    fill_const(32767, 32767);
    run_job(4, 0, 0, 0);
    fill_const(32767, -32768);
    run_job(4, 1, 2, 0);

    run_job(0, 0, 0, 0);

    fill(0);
    run_job(12, 0, 0, 0);

    fill(1);
    start = 1'b1;
    k_len = KW'(3);
    tick;
    start = 1'b0;
    drive_beat(0);
    in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    #2 reset = 1'b0;
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_in_ready", in_ready, 0);
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_out_data", out_data, 0);
    check("mid_rst_done", done, 0);
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b1;
    tick;
    run_job(3, 0, 0, 1);

    for (int n = 0; n < 24; n++) begin
      fill(1'($urandom_range(0, 1)));
      run_job(int'($urandom_range(0, KMAX + 4)),
              int'($urandom_range(0, 2)),
              int'($urandom_range(0, 2)),
              1'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
